// File: rtl/instruction_store.sv
// Loadable instruction memory for the fetch path: a streaming load port fills the array,
// then fetches return words with one-cycle latency, or HALT_WORD with an error at or past prog_len.
module instruction_store #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 4,
   parameter int                DEPTH     = 16,
   parameter logic [DATA_W-1:0] HALT_WORD = 8'hF0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_start_i,
   input  logic              load_valid_i,
   input  logic              load_last_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              load_ready_o,
   output logic              load_done_o,
   output logic [ADDR_W:0]   prog_len_o,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_ready_o,
   output logic              fetch_valid_o,
   output logic [DATA_W-1:0] fetch_data_o,
   output logic              fetch_err_o
);

   // state   | meaning
   // ST_IDLE | after reset, no program; fetches answer HALT_WORD
   // ST_LOAD | accepting program words, fetches blocked
   // ST_RUN  | program loaded, fetches served
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   wr_ptr_nxt;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic              load_done_q, load_done_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
   logic              fetch_err_q, fetch_err_d;
   logic              fetch_acc;
   logic              wr_en;

   // The array is never reset; prog_len alone decides which words are reachable.
   logic [DATA_W-1:0] mem_q [DEPTH];

   assign load_ready_o  = (state_q == ST_LOAD) && (wr_ptr_q < DEPTH_C);
   assign fetch_ready_o = (state_q != ST_LOAD);
   assign fetch_acc     = fetch_req_i && fetch_ready_o;
   assign wr_ptr_nxt    = wr_ptr_q + 1'b1;

   assign load_done_o   = load_done_q;
   assign prog_len_o    = prog_len_q;
   assign fetch_valid_o = fetch_valid_q;
   assign fetch_data_o  = fetch_data_q;
   assign fetch_err_o   = fetch_err_q;

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      prog_len_d    = prog_len_q;
      load_done_d   = 1'b0;
      fetch_valid_d = fetch_acc;
      fetch_data_d  = fetch_data_q;
      fetch_err_d   = fetch_err_q;
      wr_en         = 1'b0;

      // A fetch accepted alongside load_start still sees the old prog_len.
      if (fetch_acc) begin
         if ({1'b0, fetch_addr_i} < prog_len_q) begin
            fetch_data_d = mem_q[fetch_addr_i];
            fetch_err_d  = 1'b0;
         end else begin
            fetch_data_d = HALT_WORD;
            fetch_err_d  = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (load_start_i) begin
               state_d    = ST_LOAD;
               wr_ptr_d   = '0;
               prog_len_d = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid_i && load_ready_o) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_nxt;
               if (load_last_i || (wr_ptr_nxt == DEPTH_C)) begin
                  state_d     = ST_RUN;
                  prog_len_d  = wr_ptr_nxt;
                  load_done_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         prog_len_q    <= '0;
         load_done_q   <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= '0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         prog_len_q    <= prog_len_d;
         load_done_q   <= load_done_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_data_q  <= fetch_data_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= load_data_i;
      end
   end

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: a program-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_instruction_store;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_start = 1'b0;
   logic       load_valid = 1'b0;
   logic       load_last = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_ready;
   logic       load_done;
   logic [4:0] prog_len;
   logic       fetch_req = 1'b0;
   logic [3:0] fetch_addr = 4'h0;
   logic       fetch_ready;
   logic       fetch_valid;
   logic [7:0] fetch_data;
   logic       fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   instruction_store dut (
      .clk_i(clk), .rst_i(rst),
      .load_start_i(load_start), .load_valid_i(load_valid), .load_last_i(load_last),
      .load_data_i(load_data), .load_ready_o(load_ready), .load_done_o(load_done),
      .prog_len_o(prog_len),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
      .fetch_valid_o(fetch_valid), .fetch_data_o(fetch_data), .fetch_err_o(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Program-level model: a load is a list of words that becomes the program when it ends.
   bit         m_loading;
   logic [7:0] m_words [16];
   int         m_count;
   int         m_len;
   logic       e_valid, e_err, e_done;
   logic [7:0] e_data;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_loading = 0; m_len = 0; m_count = 0;
         e_valid = 0; e_err = 0; e_data = 8'h00; e_done = 0;
      end else begin
         e_valid = 0;
         e_done  = 0;
         if (!m_loading && fetch_req) begin
            e_valid = 1;
            if (int'(fetch_addr) < m_len) begin
               e_data = m_words[fetch_addr];
               e_err  = 0;
            end else begin
               e_data = 8'hF0;
               e_err  = 1;
            end
         end
         if (m_loading) begin
            if (load_valid) begin
               m_words[m_count] = load_data;
               m_count++;
               if (load_last || m_count == 16) begin
                  m_len     = m_count;
                  m_loading = 0;
                  e_done    = 1;
               end
            end
         end else if (load_start) begin
            m_loading = 1;
            m_count   = 0;
            m_len     = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("fetch_valid", 32'(fetch_valid), 32'(e_valid));
      chk("fetch_data", 32'(fetch_data), 32'(e_data));
      chk("fetch_err", 32'(fetch_err), 32'(e_err));
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("prog_len", 32'(prog_len), 32'(m_len));
      chk("load_ready", 32'(load_ready), 32'(m_loading));
      chk("fetch_ready", 32'(fetch_ready), 32'(!m_loading));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic vld, input logic freq);
      load_data  = d;
      load_last  = last;
      load_valid = vld;
      fetch_req  = freq;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
   endtask

   task automatic lit_fetch(input logic [3:0] a, input logic [7:0] d, input logic e);
      fetch_addr = a;
      fetch_req  = 1'b1;
      tick();
      fetch_req  = 1'b0;
      @(negedge clk);
      chk("lit_valid", 32'(fetch_valid), 32'd1);
      chk("lit_data", 32'(fetch_data), 32'(d));
      chk("lit_err", 32'(fetch_err), 32'(e));
   endtask

   task automatic load4();
      start_load();
      send(8'h52, 1'b0, 1'b1, 1'b0);
      send(8'h57, 1'b0, 1'b1, 1'b0);
      send(8'h81, 1'b0, 1'b1, 1'b0);
      send(8'hF0, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      chk("rst_fetch_data", 32'(fetch_data), 32'd0);
      chk("rst_prog_len", 32'(prog_len), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // fetch in IDLE with nothing loaded
      lit_fetch(4'd0, 8'hF0, 1'b1);

      // four-word program terminated by load_last
      load4();
      @(negedge clk);
      chk("lit_done4", 32'(load_done), 32'd1);
      chk("lit_len4", 32'(prog_len), 32'd4);
      chk("lit_rdy4", 32'(load_ready), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         fetch_addr = 4'(i);
         fetch_req  = 1'b1;
         tick();
      end
      fetch_req = 1'b0;
      tick();
      lit_fetch(4'd2, 8'h81, 1'b0);
      lit_fetch(4'd3, 8'hF0, 1'b0);
      lit_fetch(4'd4, 8'hF0, 1'b1);

      // full-depth program without load_last
      tick();
      start_load();
      for (int i = 0; i < 16; i++) send(8'(8'h10 + 3 * i), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("lit_len16", 32'(prog_len), 32'd16);
      chk("lit_rdy16", 32'(load_ready), 32'd0);
      tick();
      lit_fetch(4'd15, 8'h3D, 1'b0);
      lit_fetch(4'd0, 8'h10, 1'b0);

      // gaps in load_valid, fetches attempted during LOAD
      tick();
      start_load();
      send(8'hA1, 1'b0, 1'b1, 1'b1);
      send(8'hEE, 1'b1, 1'b0, 1'b1);
      send(8'hA2, 1'b0, 1'b1, 1'b0);
      send(8'hEE, 1'b0, 1'b0, 1'b1);
      send(8'hA3, 1'b1, 1'b1, 1'b0);
      tick();
      lit_fetch(4'd0, 8'hA1, 1'b0);
      lit_fetch(4'd1, 8'hA2, 1'b0);
      lit_fetch(4'd2, 8'hA3, 1'b0);
      lit_fetch(4'd3, 8'hF0, 1'b1);

      // reset in the middle of a load
      tick();
      start_load();
      send(8'h11, 1'b0, 1'b1, 1'b0);
      send(8'h22, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("lit_abort_rdy", 32'(load_ready), 32'd0);
      chk("lit_abort_len", 32'(prog_len), 32'd0);
      chk("lit_abort_frdy", 32'(fetch_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      lit_fetch(4'd0, 8'hF0, 1'b1);

      // fetch and load_start in the same RUN cycle
      tick();
      load4();
      tick();
      fetch_addr = 4'd1;
      fetch_req  = 1'b1;
      load_start = 1'b1;
      tick();
      fetch_req  = 1'b0;
      load_start = 1'b0;
      @(negedge clk);
      chk("lit_mix_valid", 32'(fetch_valid), 32'd1);
      chk("lit_mix_data", 32'(fetch_data), 32'h57);
      chk("lit_mix_err", 32'(fetch_err), 32'd0);
      chk("lit_mix_len", 32'(prog_len), 32'd0);
      chk("lit_mix_rdy", 32'(load_ready), 32'd1);
      chk("lit_mix_frdy", 32'(fetch_ready), 32'd0);

      // reset while a fetch response is pending
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      fetch_addr = 4'd0;
      fetch_req  = 1'b1;
      tick();
      fetch_req  = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      chk("lit_rst_fvalid", 32'(fetch_valid), 32'd0);
      tick();
      rst = 1'b0;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
